seg_dynamic_pwm: RTL and testbench

- Parametrised multiplexed 7-segment driver with DIG_NUM digits.
- Converts a binary value to BCD internally using a sequential shift-add-3 engine, or shows raw nibbles in hex mode.
- Adds leading-zero blanking, a sign digit, per-digit decimal points, per-digit blink, 16-level brightness PWM, and an overflow indication.
- Feeds the board's 74HC595 serialiser or drives the segment/select pins directly.

---
 rtl/seg_dynamic_pwm.sv | 206 ++++++++++++++++++++
 tb/tb_seg_dynamic_pwm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_dynamic_pwm.sv
// Multiplexed 7-segment driver: binary->BCD (shift-add-3) or hex nibbles, blanking,
// sign, decimal points, per-digit blink, 16-level PWM brightness and overflow dashes.
//
// state  | meaning
// S_IDLE   | first capture after reset
// S_LOAD   | seed shift register and BCD accumulator from the captured value
// S_SHIFT  | one shift-add-3 step per cycle, DATA_W cycles
// S_COMMIT | write display register and ovf, and capture the next value
module seg_dynamic_pwm #(
  parameter int DIG_NUM      = 6,
  parameter int DATA_W       = 20,
  parameter int SUB_CNT      = 3124,
  parameter int BLINK_FRAMES = 83
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [DATA_W-1:0]   data,
  input  logic [DIG_NUM-1:0]  point,
  input  logic                sign,
  input  logic                hex_mode,
  input  logic [DIG_NUM-1:0]  blink,
  input  logic [3:0]          bright,
  input  logic                seg_en,
  output logic [7:0]          seg,
  output logic [DIG_NUM-1:0]  sel,
  output logic                ovf
);

  localparam int BCD_W  = 4 * DIG_NUM;
  localparam int SCAN_W = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
  localparam int SUB_W  = (SUB_CNT > 0) ? $clog2(SUB_CNT + 1) : 1;
  localparam int BL_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SH_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  function automatic logic [63:0] dec_max(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] DEC_MAX = dec_max(DIG_NUM);

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} conv_state_t;

  conv_state_t         state;
  logic [DATA_W-1:0]   cap_data;
  logic                cap_hex;
  logic                cap_sign;
  logic [DIG_NUM-1:0]  cap_point;
  logic [DATA_W-1:0]   bin_sh;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [SH_W-1:0]     bit_cnt;
  logic [7:0]          disp      [DIG_NUM];
  logic [7:0]          disp_next [DIG_NUM];
  logic [3:0]          nib       [DIG_NUM];
  logic                ovf_next;
  logic [63:0]         cap_ext;
  int                  top;

  logic [SUB_W-1:0]    sub_cnt;
  logic [3:0]          sub_idx;
  logic [SCAN_W-1:0]   scan_idx;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_on;
  logic [DIG_NUM-1:0]  one_hot;

  assign cap_ext = {{(64-DATA_W){1'b0}}, cap_data};
  assign one_hot = DIG_NUM'(1) << scan_idx;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIG_NUM; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Truncating the BCD register to DIG_NUM digits is safe: any value that fits
  // never carries into the dropped digits, and values that do not fit show dashes.
  always_comb begin
    ovf_next = cap_hex ? ((cap_ext >> (4*DIG_NUM)) != 64'd0) : (cap_ext > DEC_MAX);
    top = 0;
    for (int i = 0; i < DIG_NUM; i++) begin
      nib[i] = cap_hex ? cap_ext[4*i +: 4] : bcd[4*i +: 4];
      if (nib[i] != 4'd0 || cap_point[i]) top = i;
    end
    for (int i = 0; i < DIG_NUM; i++) begin
      if (ovf_next)                   disp_next[i] = 8'hBF;
      else if (i <= top)              disp_next[i] = {~cap_point[i], seg7(nib[i])};
      else if (cap_sign && i == top + 1) disp_next[i] = 8'hBF;
      else                            disp_next[i] = 8'hFF;
    end
  end

  // Commit doubles as the next capture, so the converter free-runs without an idle bubble.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      cap_data  <= '0;
      cap_hex   <= 1'b0;
      cap_sign  <= 1'b0;
      cap_point <= '0;
      bin_sh    <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      ovf       <= 1'b0;
      for (int i = 0; i < DIG_NUM; i++) disp[i] <= 8'hFF;
    end else begin
      case (state)
        S_IDLE: begin
          cap_data  <= data;
          cap_hex   <= hex_mode;
          cap_sign  <= sign;
          cap_point <= point;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          bin_sh  <= cap_data;
          bcd     <= '0;
          bit_cnt <= SH_W'(DATA_W - 1);
          state   <= cap_hex ? S_COMMIT : S_SHIFT;
        end
        S_SHIFT: begin
          bcd    <= (bcd_adj << 1) | BCD_W'(bin_sh[DATA_W-1]);
          bin_sh <= bin_sh << 1;
          if (bit_cnt == '0) state <= S_COMMIT;
          else               bit_cnt <= bit_cnt - 1'b1;
        end
        S_COMMIT: begin
          disp      <= disp_next;
          ovf       <= ovf_next;
          cap_data  <= data;
          cap_hex   <= hex_mode;
          cap_sign  <= sign;
          cap_point <= point;
          state     <= S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sub_cnt   <= SUB_W'(SUB_CNT);
      sub_idx   <= 4'd0;
      scan_idx  <= '0;
      blink_cnt <= BL_W'(BLINK_FRAMES - 1);
      blink_on  <= 1'b1;
    end else if (sub_cnt == '0) begin
      sub_cnt <= SUB_W'(SUB_CNT);
      sub_idx <= sub_idx + 4'd1;
      if (sub_idx == 4'hF) begin
        if (scan_idx == SCAN_W'(DIG_NUM - 1)) begin
          scan_idx <= '0;
          if (blink_cnt == '0) begin
            blink_cnt <= BL_W'(BLINK_FRAMES - 1);
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt - 1'b1;
          end
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
    end else begin
      sub_cnt <= sub_cnt - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg <= 8'hFF;
      sel <= '0;
    end else if (seg_en && sub_idx <= bright) begin
      sel <= one_hot;
      seg <= (!blink_on && blink[scan_idx]) ? 8'hFF : disp[scan_idx];
    end else begin
      sel <= '0;
      seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_pwm.sv
// Directed bench for seg_dynamic_pwm with a short PWM sub-slot and 2-frame blink.
module tb_seg_dynamic_pwm;
  localparam int DIG_NUM      = 6;
  localparam int DATA_W       = 20;
  localparam int SUB_CNT      = 3;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT         = 16 * (SUB_CNT + 1);
  localparam int FRAME        = SLOT * DIG_NUM;
  localparam int SETTLE       = 60;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [DATA_W-1:0]  data = '0;
  logic [DIG_NUM-1:0] point = '0;
  logic               sign = 1'b0;
  logic               hex_mode = 1'b0;
  logic [DIG_NUM-1:0] blink = '0;
  logic [3:0]         bright = 4'd15;
  logic               seg_en = 1'b1;
  logic [7:0]         seg;
  logic [DIG_NUM-1:0] sel;
  logic               ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] seg_seen [DIG_NUM];
  int         on_cnt   [DIG_NUM];
  int         multi_hot;
  int         dark_lit;
  logic [7:0] v0 [8];

  seg_dynamic_pwm #(
    .DIG_NUM(DIG_NUM), .DATA_W(DATA_W), .SUB_CNT(SUB_CNT), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point), .sign(sign),
    .hex_mode(hex_mode), .blink(blink), .bright(bright), .seg_en(seg_en),
    .seg(seg), .sel(sel), .ovf(ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp)
      else begin
        err_cnt++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic scan_frame();
    for (int i = 0; i < DIG_NUM; i++) begin
      seg_seen[i] = 8'h00;
      on_cnt[i]   = 0;
    end
    multi_hot = 0;
    dark_lit  = 0;
    repeat (FRAME) begin
      @(negedge sys_clk);
      if ($countones(sel) > 1) multi_hot++;
      if (sel == '0 && seg !== 8'hFF) dark_lit++;
      for (int i = 0; i < DIG_NUM; i++) begin
        if (sel[i]) begin
          on_cnt[i]++;
          seg_seen[i] = seg;
        end
      end
    end
  endtask

  // exp_seg packs digit i at bits [8*i +: 8]
  task automatic check_frame(input string tag, input logic [8*DIG_NUM-1:0] exp_seg,
                             input int exp_on);
    scan_frame();
    for (int i = 0; i < DIG_NUM; i++) begin
      check($sformatf("%s seg%0d", tag, i), 32'(seg_seen[i]), 32'(exp_seg[8*i +: 8]));
      check($sformatf("%s on%0d", tag, i), on_cnt[i], exp_on);
    end
    check({tag, " multi_hot"}, multi_hot, 0);
    check({tag, " dark_lit"}, dark_lit, 0);
  endtask

  initial begin
    int  n0, d1_bad, lat;
    logic p0, p1, found;

    repeat (3) @(negedge sys_clk);
    check("rst seg", 32'(seg), 32'hFF);
    check("rst sel", 32'(sel), 32'h0);
    check("rst ovf", 32'(ovf), 32'h0);

    // 1234 with sign: 4,3,2,1,'-',blank
    data = 20'd1234; sign = 1'b1;
    sys_rst_n = 1'b1;
    repeat (SETTLE) @(negedge sys_clk);
    check_frame("t1", {8'hFF, 8'hBF, 8'hF9, 8'hA4, 8'hB0, 8'h99}, SLOT);
    check("t1 ovf", 32'(ovf), 32'h0);

    // zero with a DP on digit 2 keeps digits 0..2
    data = 20'd0; point = 6'b000100; sign = 1'b0;
    repeat (SETTLE) @(negedge sys_clk);
    check_frame("t2", {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0}, SLOT);

    point = '0; hex_mode = 1'b1; data = 20'hABCDE;
    repeat (SETTLE) @(negedge sys_clk);
    check_frame("t3hex", {8'hFF, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86}, SLOT);
    check("t3hex ovf", 32'(ovf), 32'h0);

    hex_mode = 1'b0; data = 20'd1000000;
    repeat (SETTLE) @(negedge sys_clk);
    check_frame("t3ovf", {DIG_NUM{8'hBF}}, SLOT);
    check("t3ovf ovf", 32'(ovf), 32'h1);

    // largest representable value; the sign has no room and is dropped
    data = 20'd999999; sign = 1'b1;
    repeat (SETTLE) @(negedge sys_clk);
    check_frame("t3max", {DIG_NUM{8'h90}}, SLOT);
    check("t3max ovf", 32'(ovf), 32'h0);

    data = 20'd1234; bright = 4'd3;
    repeat (SETTLE) @(negedge sys_clk);
    check_frame("t4b3", {8'hFF, 8'hBF, 8'hF9, 8'hA4, 8'hB0, 8'h99}, 16);
    bright = 4'd0;
    check_frame("t4b0", {8'hFF, 8'hBF, 8'hF9, 8'hA4, 8'hB0, 8'h99}, 4);

    // blink digit 0: sample it at each slot-0 start over 8 frames
    bright = 4'd15; blink = 6'b000001;
    for (int k = 0; k < 8; k++) v0[k] = 8'h00;
    n0 = 0; d1_bad = 0; p0 = 1'b1; p1 = 1'b1;
    for (int c = 0; c < 10 * FRAME && n0 < 8; c++) begin
      @(negedge sys_clk);
      if (sel[0] && !p0) begin
        v0[n0] = seg;
        n0++;
      end
      if (sel[1] && !p1 && seg !== 8'hB0) d1_bad++;
      p0 = sel[0];
      p1 = sel[1];
    end
    check("t5 slots", n0, 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("t5 val%0d", k), 32'(v0[k] == 8'h99 || v0[k] == 8'hFF), 32'h1);
    for (int k = 0; k < 6; k++)
      check($sformatf("t5 alt%0d", k), 32'((v0[k] == 8'hFF) ^ (v0[k+2] == 8'hFF)), 32'h1);
    check("t5 dig1", d1_bad, 0);
    blink = '0;

    repeat (SLOT / 2) @(negedge sys_clk);
    check("t6 lit", 32'(sel != '0), 32'h1);
    seg_en = 1'b0;
    @(negedge sys_clk);
    check("t6 off sel", 32'(sel), 32'h0);
    check("t6 off seg", 32'(seg), 32'hFF);
    seg_en = 1'b1;
    @(negedge sys_clk);
    check("t6 on onehot", $countones(sel), 1);

    data = 20'd1000000; sign = 1'b0;
    repeat (SETTLE) @(negedge sys_clk);
    check("t6 pre ovf", 32'(ovf), 32'h1);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6 rst seg", 32'(seg), 32'hFF);
    check("t6 rst sel", 32'(sel), 32'h0);
    check("t6 rst ovf", 32'(ovf), 32'h0);

    data = 20'd1234; sign = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    found = 1'b0; lat = 0;
    for (int c = 1; c <= 2 * (DATA_W + 2) + SLOT && !found; c++) begin
      @(negedge sys_clk);
      if (sel != '0 && seg !== 8'hFF) begin
        found = 1'b1;
        lat = c;
      end
    end
    check("t6 latency", 32'(found), 32'h1);
    check("t6 first seg", 32'(seg), 32'h99);
    check("t6 first sel", 32'(sel), 32'h1);
    if (!found) $display("t6 latency bound expired after %0d cycles", lat);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
